// File: rtl/usi_uart_master.sv
// usi_uart_master: UART 8N1 host bridge that turns write/read command frames
// into single USI bus transactions and returns ACK/NAK plus read data.
// Parameter constraints: pUsiBusWidth in {8,16,24,32}, pBaudDiv >= 4.
module usi_uart_master #(
    parameter int pBlockConnectNum = 1,
    parameter int pUsiBusWidth     = 16,
    parameter int pBaudDiv         = 434,
    parameter int pRdTimeout       = 255
) (
    input  logic                        iSCLK,
    input  logic                        iSRST,
    input  logic                        iUartRx,
    output logic                        oUartTx,
    input  logic [31:0]                 iMUsiRd,
    input  logic [pBlockConnectNum-1:0] iMUsiREd,
    output logic [31:0]                 oMUsiWd,
    output logic [pUsiBusWidth-1:0]     oMUsiAdrs,
    output logic                        oMUsiWEd,
    output logic                        oMUsiRdReq
);

    localparam int BCW = $clog2(pBaudDiv);
    localparam int TOW = $clog2(pRdTimeout + 1);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(pBaudDiv - 1);
    localparam logic [BCW-1:0] BAUD_HALF = BCW'(pBaudDiv / 2 - 1);
    localparam logic [BCW-1:0] BAUD_ONE  = BCW'(1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(pRdTimeout - 1);
    localparam logic [TOW-1:0] TO_ONE    = TOW'(1);
    localparam logic [2:0]     AB_LAST   = 3'(pUsiBusWidth / 8 - 1);
    localparam logic [7:0]     CMD_WR    = 8'h57;
    localparam logic [7:0]     CMD_RD    = 8'h52;
    localparam logic [7:0]     RESP_ACK  = 8'h06;
    localparam logic [7:0]     RESP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_ADRS, S_DATA, S_BUS_WR, S_BUS_RD, S_WAIT_RD, S_RESP, S_TX_DATA
    } state_t;

    state_t state_r, state_nx_s;

    // receiver state
    logic       rx_meta_r, rx_sync_r, rx_prev_r, rx_busy_r, rx_valid_r, rx_ferr_r;
    logic [BCW-1:0] rx_cnt_r;
    logic [3:0] rx_bit_r;
    logic [7:0] rx_sh_r;

    // transmitter state
    logic       tx_busy_r;
    logic [BCW-1:0] tx_cnt_r;
    logic [3:0] tx_bit_r;
    logic [7:0] tx_sh_r;

    // control / datapath
    logic       is_wr_r, rd_pend_r;
    logic [2:0] cnt_r;
    logic [TOW-1:0] to_cnt_r;
    logic [31:0] rd_data_r;
    logic [7:0] resp_byte_r;
    logic [pUsiBusWidth-1:0] adrs_nx_s;
    logic       is_cmd_s, red_any_s, ack_s;
    logic       cmd_ld_s, adrs_sh_s, data_sh_s, cap_s, cnt_inc_s, tx_start_s;
    logic [7:0] tx_byte_s;

    assign is_cmd_s  = (rx_sh_r == CMD_WR) || (rx_sh_r == CMD_RD);
    assign red_any_s = |iMUsiREd;
    assign ack_s     = (state_r == S_BUS_WR) || ((state_r == S_WAIT_RD) && red_any_s);

    // Next address value: shift the received byte in at the LSB end.
    generate
        if (pUsiBusWidth == 8) begin : g_adrs8
            assign adrs_nx_s = rx_sh_r;
        end else begin : g_adrsn
            assign adrs_nx_s = {oMUsiAdrs[pUsiBusWidth-9:0], rx_sh_r};
        end
    endgenerate

    // UART receiver: synchronize, detect start edge, sample mid-bit, flag byte or framing error.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_busy_r  <= 1'b0;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 4'd0;
            rx_sh_r    <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_meta_r  <= iUartRx;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            if (!rx_busy_r) begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_busy_r <= 1'b1;
                    rx_cnt_r  <= BAUD_HALF;
                    rx_bit_r  <= 4'd0;
                end
            end else if (rx_cnt_r != '0) begin
                rx_cnt_r <= rx_cnt_r - BAUD_ONE;
            end else begin
                rx_cnt_r <= BAUD_LAST;
                if (rx_bit_r == 4'd0) begin
                    // a start bit that is high again by mid-bit was a glitch
                    if (rx_sync_r) begin
                        rx_busy_r <= 1'b0;
                    end else begin
                        rx_bit_r <= 4'd1;
                    end
                end else if (rx_bit_r <= 4'd8) begin
                    rx_sh_r  <= {rx_sync_r, rx_sh_r[7:1]};
                    rx_bit_r <= rx_bit_r + 4'd1;
                end else begin
                    rx_busy_r <= 1'b0;
                    if (rx_sync_r) begin
                        rx_valid_r <= 1'b1;
                    end else begin
                        rx_ferr_r <= 1'b1;
                    end
                end
            end
        end
    end

    // UART transmitter: start bit, 8 data bits LSB first, stop bit; busy until stop completes.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            oUartTx   <= 1'b1;
            tx_busy_r <= 1'b0;
            tx_cnt_r  <= '0;
            tx_bit_r  <= 4'd0;
            tx_sh_r   <= 8'h00;
        end else if (!tx_busy_r) begin
            if (tx_start_s) begin
                oUartTx   <= 1'b0;
                tx_sh_r   <= tx_byte_s;
                tx_bit_r  <= 4'd0;
                tx_cnt_r  <= BAUD_LAST;
                tx_busy_r <= 1'b1;
            end
        end else if (tx_cnt_r != '0) begin
            tx_cnt_r <= tx_cnt_r - BAUD_ONE;
        end else begin
            tx_cnt_r <= BAUD_LAST;
            if (tx_bit_r < 4'd8) begin
                oUartTx  <= tx_sh_r[0];
                tx_sh_r  <= {1'b0, tx_sh_r[7:1]};
                tx_bit_r <= tx_bit_r + 4'd1;
            end else if (tx_bit_r == 4'd8) begin
                oUartTx  <= 1'b1;
                tx_bit_r <= 4'd9;
            end else begin
                tx_busy_r <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode; received bytes are only consumed in IDLE/ADRS/DATA.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (rx_ferr_r) begin
                    state_nx_s = S_RESP;
                end else if (rx_valid_r) begin
                    state_nx_s = is_cmd_s ? S_ADRS : S_RESP;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ADRS: begin
                if (rx_ferr_r) begin
                    state_nx_s = S_RESP;
                end else if (rx_valid_r && (cnt_r == AB_LAST)) begin
                    state_nx_s = is_wr_r ? S_DATA : S_BUS_RD;
                end else begin
                    state_nx_s = S_ADRS;
                end
            end
            S_DATA: begin
                if (rx_ferr_r) begin
                    state_nx_s = S_RESP;
                end else if (rx_valid_r && (cnt_r == 3'd3)) begin
                    state_nx_s = S_BUS_WR;
                end else begin
                    state_nx_s = S_DATA;
                end
            end
            S_BUS_WR: state_nx_s = S_RESP;
            S_BUS_RD: state_nx_s = S_WAIT_RD;
            S_WAIT_RD: begin
                // read data wins over a timeout expiring in the same cycle
                if (red_any_s) begin
                    state_nx_s = S_RESP;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nx_s = S_RESP;
                end else begin
                    state_nx_s = S_WAIT_RD;
                end
            end
            S_RESP: begin
                if (!tx_busy_r) begin
                    state_nx_s = rd_pend_r ? S_TX_DATA : S_IDLE;
                end else begin
                    state_nx_s = S_RESP;
                end
            end
            S_TX_DATA: begin
                if (!tx_busy_r && (cnt_r == 3'd3)) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_TX_DATA;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // FSM output decode: datapath enables and TX byte selection.
    always_comb begin
        cmd_ld_s   = 1'b0;
        adrs_sh_s  = 1'b0;
        data_sh_s  = 1'b0;
        cap_s      = 1'b0;
        cnt_inc_s  = 1'b0;
        tx_start_s = 1'b0;
        tx_byte_s  = 8'h00;
        case (state_r)
            S_IDLE:    cmd_ld_s = rx_valid_r && is_cmd_s;
            S_ADRS: begin
                adrs_sh_s = rx_valid_r;
                cnt_inc_s = rx_valid_r;
            end
            S_DATA: begin
                data_sh_s = rx_valid_r;
                cnt_inc_s = rx_valid_r;
            end
            S_WAIT_RD: cap_s = red_any_s;
            S_RESP: begin
                tx_start_s = !tx_busy_r;
                tx_byte_s  = resp_byte_r;
            end
            S_TX_DATA: begin
                tx_start_s = !tx_busy_r;
                cnt_inc_s  = !tx_busy_r;
                case (cnt_r[1:0])
                    2'd0:    tx_byte_s = rd_data_r[31:24];
                    2'd1:    tx_byte_s = rd_data_r[23:16];
                    2'd2:    tx_byte_s = rd_data_r[15:8];
                    default: tx_byte_s = rd_data_r[7:0];
                endcase
            end
            default: tx_byte_s = 8'h00;
        endcase
    end

    // Datapath: bus registers, byte/timeout counters, response and read-data capture.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            oMUsiWd     <= 32'h0000_0000;
            oMUsiAdrs   <= '0;
            oMUsiWEd    <= 1'b0;
            oMUsiRdReq  <= 1'b0;
            is_wr_r     <= 1'b0;
            rd_pend_r   <= 1'b0;
            cnt_r       <= 3'd0;
            to_cnt_r    <= '0;
            rd_data_r   <= 32'h0000_0000;
            resp_byte_r <= 8'h00;
        end else begin
            // strobes follow the bus states so address/data are stable a cycle earlier
            oMUsiWEd   <= (state_r == S_BUS_WR);
            oMUsiRdReq <= (state_r == S_BUS_RD);
            if (cmd_ld_s) begin
                is_wr_r <= (rx_sh_r == CMD_WR);
            end
            if (adrs_sh_s) begin
                oMUsiAdrs <= adrs_nx_s;
            end
            if (data_sh_s) begin
                oMUsiWd <= {oMUsiWd[23:0], rx_sh_r};
            end
            if (state_nx_s != state_r) begin
                cnt_r <= 3'd0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + 3'd1;
            end
            if (state_r == S_BUS_RD) begin
                to_cnt_r <= '0;
            end else if (state_r == S_WAIT_RD) begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end
            if (cap_s) begin
                rd_data_r <= iMUsiRd;
            end
            if ((state_r != S_RESP) && (state_nx_s == S_RESP)) begin
                resp_byte_r <= ack_s ? RESP_ACK : RESP_NAK;
                rd_pend_r   <= (state_r == S_WAIT_RD) && red_any_s;
            end
        end
    end

endmodule
